serial_shift_tx: RTL and testbench
==================================

Name: serial_shift_tx

Overview:
Parallel-in, serial-out frame transmitter: the transmit end of the team's serial shift link, feeding the existing shift-register/flip-flop receive chain. Accepts one DATA_W word per valid/ready handshake and shifts it out on a single line, LSB first. Framing is a start bit, the data bits, an optional even-parity bit and a stop bit, each held for CLKS_PER_BIT clocks. The block sits between a parallel producer and the serial line.

Parameters:
DATA_W, 8, data bits per frame (>=1)
CLKS_PER_BIT, 4, clock cycles each serial bit is held (>=1; 1 must work)
PARITY_EN, 0, 1 inserts an even-parity bit after the data bits

Ports:
Clk  input  1  single clock; all state updates on rising edge
Reset_n  input  1  asynchronous, active-low reset
Data_In  input  DATA_W  parallel word; sampled only on the handshake edge
Load_Valid  input  1  producer has a word on Data_In
Load_Ready  output  1  transmitter can accept a word (high only in IDLE)
Tx  output  1  serial line; idles high
Busy  output  1  high in START/DATA/PARITY/STOP
Done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Reset (Reset_n=0, async): state=IDLE, Tx=1, Busy=0, Done=0, Load_Ready=1, shift register/counters=0. Asserting reset mid-frame aborts the frame immediately; no partial Done.
- All outputs are registered or decoded from registered state only. No combinational path from Load_Valid to Load_Ready.
- Handshake: a word is accepted on a rising edge where Load_Valid=1 and Load_Ready=1. Data_In is captured into the shift register on that edge.
  - Load_Valid while Busy is ignored: no capture, no queuing.
  - Data_In changes after acceptance have no effect.
- FSM: IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE.
  - IDLE: Tx=1. On accept, go to START; Tx=0 from the next cycle.
  - START: Tx=0 for CLKS_PER_BIT cycles.
  - DATA: Tx=shift_reg[0]. After each CLKS_PER_BIT cycles, shift right and increment bit_idx. After bit DATA_W-1 completes, leave DATA. bit_idx wraps to 0.
  - PARITY: Tx = XOR of the captured word (even parity) for CLKS_PER_BIT cycles.
  - STOP: Tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Done pulses high for exactly the first IDLE cycle after STOP.
- Frame length: Tx is non-idle/framed for (DATA_W+2+PARITY_EN)*CLKS_PER_BIT cycles after the accept edge.
- Back-to-back: with Load_Valid held high, the next accept occurs on the first IDLE edge. Frame period = (DATA_W+2+PARITY_EN)*CLKS_PER_BIT+1 cycles. The single idle-high cycle between frames is required.
- Widths: bit-period counter is $clog2(CLKS_PER_BIT+1) bits; bit_idx is $clog2(DATA_W+1) bits. No counter may overflow at parameter extremes (CLKS_PER_BIT=1, DATA_W=1).
- X-safety: Tx must never be X after reset release, regardless of Data_In.

Decomposition:
- Package serial_tx_pkg: state enum (IDLE, START, DATA, PARITY, STOP) and localparam helper for frame-length calculation, shared with the bench.
- One sub-module, bit_timer: counts CLKS_PER_BIT cycles and emits bit_end; cleared on accept and on reset.
- The FSM and shift register stay in the top module.

Test Plan:
- Reset idle: hold Reset_n=0 5 cycles, release, Load_Valid=0 -> Tx=1, Load_Ready=1, Busy=0, Done=0 for 20 cycles.
- Single frame (DATA_W=8, CLKS_PER_BIT=4, PARITY_EN=0): send 0xA5.
  - Tx sequence, 4 cycles each: 0, 1,0,1,0,0,1,0,1, 1.
  - Busy high 40 cycles; Done pulses exactly once, on cycle 41.
- Parity (PARITY_EN=1): send 0xA5 -> parity bit 0; send 0x07 -> parity bit 1. Frame = 44 cycles.
- Back-to-back: Load_Valid held high, words 0x00 then 0xFF.
  - Second start bit begins exactly 41 cycles after the first accept.
  - Load_Valid while Busy does not corrupt the frame.
- Reset mid-frame: assert Reset_n=0 during DATA bit 3 -> Tx=1 within the same cycle (async), no Done.
  - Next frame 0x3C transmits correctly.
- Edge parameters (CLKS_PER_BIT=1, DATA_W=1): send 1 -> Tx 0,1,1 one cycle each; Done on cycle 4.

Source files
------------

// File: rtl/serial_shift_tx_pkg.sv
// Shared types and helpers for the serial shift-link transmitter.
// Imported by the RTL and the bench.
package serial_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Busy cycles of one frame, measured from the accept edge.
    function automatic int frame_cycles(input int data_w, input int cpb,
                                        input int par_en);
        return (data_w + 2 + par_en) * cpb;
    endfunction

endpackage

// File: rtl/serial_shift_tx_if.sv
// Parallel load handshake between producer and transmitter.
// Data_In is valid alongside Load_Valid and is taken when Load_Ready is high.
interface serial_shift_tx_if #(
    parameter int DATA_W = 8
) ();

    logic [DATA_W-1:0] Data_In;
    logic              Load_Valid;
    logic              Load_Ready;

    modport master (
        output Data_In,
        output Load_Valid,
        input  Load_Ready
    );

    modport slave (
        input  Data_In,
        input  Load_Valid,
        output Load_Ready
    );

endinterface

// File: rtl/serial_shift_tx_bit_timer.sv
// Bit-period timer: bit_end marks the last clock of each serial bit.
// Cleared on accept so every frame starts on a fresh bit period.
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic clear,
    input  logic run,
    output logic bit_end
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign bit_end = run && (cnt == LAST);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt <= '0;
        end else if (clear || !run || bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/serial_shift_tx.sv
// Parallel-in, serial-out frame transmitter, LSB first.
// Frame: start, data, optional even parity, stop; each bit CLKS_PER_BIT clocks.
module serial_shift_tx
    import serial_tx_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    serial_shift_tx_if.slave     load,
    output logic                 Tx,
    output logic                 Busy,
    output logic                 Done
);

    localparam int IW = $clog2(DATA_W + 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_W - 1);

    tx_state_t         state;
    tx_state_t         state_nx;
    logic [DATA_W-1:0] shift_reg;
    logic [IW-1:0]     bit_idx;
    logic              par_bit;
    logic              done_q;
    logic              accept;
    logic              bit_end;
    logic              last_bit;

    assign accept          = load.Load_Valid && (state == IDLE);
    assign last_bit        = (bit_idx == LAST_BIT);
    assign load.Load_Ready = (state == IDLE);
    assign Busy            = (state != IDLE);
    assign Done            = done_q;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .clear  (accept),
        .run    (Busy),
        .bit_end(bit_end)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:   if (accept) state_nx = START;
            START:  if (bit_end) state_nx = DATA;
            DATA: begin
                if (bit_end && last_bit)
                    state_nx = (PARITY_EN != 0) ? PARITY : STOP;
            end
            PARITY: if (bit_end) state_nx = STOP;
            STOP:   if (bit_end) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Line level is decoded from registered state only.
    always_comb begin
        Tx = 1'b1;
        unique case (state)
            START:   Tx = 1'b0;
            DATA:    Tx = shift_reg[0];
            PARITY:  Tx = par_bit;
            default: Tx = 1'b1;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            shift_reg <= '0;
            bit_idx   <= '0;
            par_bit   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= (state == STOP) && bit_end;
            if (accept) begin
                shift_reg <= load.Data_In;
                par_bit   <= ^load.Data_In;
                bit_idx   <= '0;
            end else if ((state == DATA) && bit_end) begin
                shift_reg <= shift_reg >> 1;
                bit_idx   <= last_bit ? '0 : bit_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_shift_tx.sv
// Scoreboard bench for serial_shift_tx across three parameter sets.
// Stimulus queues expected wire bits; per-DUT monitors compare on Done.
module tb_serial_shift_tx;
    import serial_tx_pkg::*;

    logic Clk;
    logic Reset_n;
    int   errors;
    int   checks;
    int   cyc;

    logic tx_w   [3];
    logic busy_w [3];
    logic done_w [3];

    string expq [3][$];
    int    start_cyc [$];
    logic  prev_tx0;

    serial_shift_tx_if #(.DATA_W(8)) if0 ();
    serial_shift_tx_if #(.DATA_W(8)) if1 ();
    serial_shift_tx_if #(.DATA_W(1)) if2 ();

    serial_shift_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) dut0 (
        .Clk(Clk), .Reset_n(Reset_n), .load(if0),
        .Tx(tx_w[0]), .Busy(busy_w[0]), .Done(done_w[0])
    );

    serial_shift_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut1 (
        .Clk(Clk), .Reset_n(Reset_n), .load(if1),
        .Tx(tx_w[1]), .Busy(busy_w[1]), .Done(done_w[1])
    );

    serial_shift_tx #(.DATA_W(1), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut2 (
        .Clk(Clk), .Reset_n(Reset_n), .load(if2),
        .Tx(tx_w[2]), .Busy(busy_w[2]), .Done(done_w[2])
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: sim time exceeded, required finish");
        $fatal(1, "watchdog");
    end

    // Start-bit edges on dut0, for the back-to-back period check.
    always @(negedge Clk) begin
        if (Reset_n && prev_tx0 && !tx_w[0]) start_cyc.push_back(cyc);
        prev_tx0 <= tx_w[0];
    end

    for (genvar g = 0; g < 3; g++) begin : mon
        localparam int CPB  = (g == 2) ? 1 : 4;
        localparam int FLEN = (g == 0) ? frame_cycles(8, 4, 0) :
                              (g == 1) ? frame_cycles(8, 4, 1) :
                                         frame_cycles(1, 1, 0);
        string log_s;
        string exp_s;
        string expd;
        logic  prev_busy;

        always @(negedge Clk) begin
            if (!Reset_n) begin
                log_s     = "";
                prev_busy = 1'b0;
            end else begin
                if (done_w[g]) begin
                    checks++;
                    if (expq[g].size() == 0) begin
                        errors++;
                        $display("FAIL done%0d: Done=1 with no frame pending", g);
                    end else begin
                        exp_s = expq[g].pop_front();
                        expd  = "";
                        for (int i = 0; i < exp_s.len(); i++)
                            for (int k = 0; k < CPB; k++)
                                expd = {expd, exp_s.substr(i, i)};
                        checks++;
                        if (log_s.len() != FLEN) begin
                            errors++;
                            $display("FAIL len%0d: busy %0d cycles, required %0d",
                                     g, log_s.len(), FLEN);
                        end
                        checks++;
                        if (log_s != expd) begin
                            errors++;
                            $display("FAIL seq%0d: got %s required %s", g, log_s, expd);
                        end
                        if (!prev_busy) begin
                            errors++;
                            $display("FAIL donepos%0d: Done not first idle cycle", g);
                        end
                    end
                    log_s = "";
                end
                if (busy_w[g]) log_s = {log_s, tx_w[g] ? "1" : "0"};
                prev_busy = busy_w[g];
            end
        end
    end

    function automatic logic get_ready(input int idx);
        case (idx)
            0:       return if0.Load_Ready;
            1:       return if1.Load_Ready;
            default: return if2.Load_Ready;
        endcase
    endfunction

    task automatic set_in(input int idx, input logic v, input logic [7:0] d);
        case (idx)
            0: begin if0.Load_Valid = v; if0.Data_In = d; end
            1: begin if1.Load_Valid = v; if1.Data_In = d; end
            default: begin if2.Load_Valid = v; if2.Data_In = d[0]; end
        endcase
    endtask

    task automatic wait_ready(input int idx);
        int n = 0;
        @(negedge Clk);
        while (!get_ready(idx) && n < 200) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL ready%0d: Load_Ready=0 after 200 cycles, required 1", idx);
        end
    endtask

    task automatic send(input int idx, input logic [7:0] d, input string exp_s,
                        input bit push);
        wait_ready(idx);
        set_in(idx, 1'b1, d);
        if (push) expq[idx].push_back(exp_s);
        @(posedge Clk);
        #1;
        set_in(idx, 1'b0, 8'($urandom));
    endtask

    task automatic wait_drain(input int idx);
        int n = 0;
        while ((expq[idx].size() != 0 || busy_w[idx]) && n < 300) begin
            @(negedge Clk);
            n++;
        end
        @(negedge Clk);
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        cyc      = 0;
        prev_tx0 = 1'b1;
        Reset_n  = 1'b0;
        set_in(0, 1'b0, 8'h00);
        set_in(1, 1'b0, 8'h00);
        set_in(2, 1'b0, 8'h00);
        repeat (5) @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            checks++;
            if (tx_w[0] !== 1'b1 || if0.Load_Ready !== 1'b1 ||
                busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) begin
                errors++;
                $display("FAIL idle c%0d: tx/rdy/busy/done=%b%b%b%b required 1100",
                         i, tx_w[0], if0.Load_Ready, busy_w[0], done_w[0]);
            end
        end

        send(0, 8'hA5, "0101001011", 1);
        wait_drain(0);

        send(1, 8'hA5, "01010010101", 1);
        wait_drain(1);
        send(1, 8'h07, "01110000011", 1);
        wait_drain(1);

        // Back-to-back: valid held high, Data_In changed while busy.
        start_cyc.delete();
        wait_ready(0);
        set_in(0, 1'b1, 8'h00);
        expq[0].push_back("0000000001");
        expq[0].push_back("0111111111");
        @(posedge Clk);
        #1;
        set_in(0, 1'b1, 8'hFF);
        wait_ready(0);
        @(posedge Clk);
        #1;
        set_in(0, 1'b0, 8'h5A);
        wait_drain(0);
        checks++;
        if (start_cyc.size() != 2) begin
            errors++;
            $display("FAIL b2b_count: %0d start edges, required 2", start_cyc.size());
        end else if (start_cyc[1] - start_cyc[0] != 41) begin
            errors++;
            $display("FAIL b2b_period: %0d cycles, required 41",
                     start_cyc[1] - start_cyc[0]);
        end

        // Abort during data bit 3 of 0x00 (line low), then send 0x3C.
        send(0, 8'h00, "", 0);
        repeat (17) @(posedge Clk);
        #2;
        checks++;
        if (tx_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL pre_abort: tx=%b busy=%b required tx=0 busy=1",
                     tx_w[0], busy_w[0]);
        end
        Reset_n = 1'b0;
        #1;
        checks++;
        if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL abort: tx/busy/done=%b%b%b required 100",
                     tx_w[0], busy_w[0], done_w[0]);
        end
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (50) @(negedge Clk);
        send(0, 8'h3C, "0001111001", 1);
        wait_drain(0);

        send(2, 8'h01, "011", 1);
        wait_drain(2);

        repeat (10) @(negedge Clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (expq[d].size() != 0) begin
                errors++;
                $display("FAIL pending%0d: %0d frames missing, required 0",
                         d, expq[d].size());
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
